// File: rtl/al_accel_config_loader_pkg.sv
// Shared definitions for the accelerator config loader and the config
// register block it writes.
//   NUM_REGS   : number of config registers (valid sel 0..NUM_REGS-1)
//   SEL_W      : width of config_sel / first_sel / reg_count
//   CFG_DATA_W : width of a config word
//   state_t    : loader FSM states
package al_accel_cfg_pkg;
  localparam int NUM_REGS   = 11;
  localparam int SEL_W      = 4;
  localparam int CFG_DATA_W = 32;
  localparam int CFG_SEL_W  = SEL_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;
endpackage

// File: rtl/al_accel_config_loader_if.sv
// Memory-read and config-write bus between the loader and its neighbours.
//   mem_req_valid/ready/addr : read request (loader -> fabric)
//   mem_rsp_valid/data       : read response (fabric -> loader)
//   config_data/sel/wen      : config register write (loader -> reg block)
// master = loader side, slave = fabric / register-block side.
interface al_accel_config_loader_if #(
  parameter int ADDR_W = 32,
  parameter int SEL_W  = al_accel_cfg_pkg::CFG_SEL_W
);
  logic                                  mem_req_valid;
  logic                                  mem_req_ready;
  logic [ADDR_W-1:0]                     mem_req_addr;
  logic                                  mem_rsp_valid;
  logic [al_accel_cfg_pkg::CFG_DATA_W-1:0] mem_rsp_data;
  logic [al_accel_cfg_pkg::CFG_DATA_W-1:0] config_data;
  logic [SEL_W-1:0]                      config_sel;
  logic                                  config_wen;

  modport master (
    output mem_req_valid, mem_req_addr, config_data, config_sel, config_wen,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, config_data, config_sel, config_wen,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/al_accel_config_loader.sv
// DMA-style config loader: on start, reads reg_count consecutive words from
// base_addr and writes each to config register first_sel+i, then pulses done.
// Ports:
//   clk, resetn          : clock, async active-low reset
//   start, abort         : load request / cancel
//   base_addr, first_sel,
//   reg_count            : load descriptor, sampled on start
//   busy, done, err      : status (done/err are one-cycle pulses)
//   bus (master)         : memory read request/response + config write
module al_accel_config_loader #(
  parameter int NUM_REGS = al_accel_cfg_pkg::NUM_REGS,
  parameter int SEL_W    = al_accel_cfg_pkg::SEL_W,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [SEL_W-1:0]  first_sel,
  input  logic [SEL_W-1:0]  reg_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  al_accel_config_loader_if.master bus
);
  import al_accel_cfg_pkg::*;

  localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W+1)'(NUM_REGS);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     base_q;
  logic [SEL_W-1:0]      first_q, count_q, idx_q, sel_q;
  logic [CFG_DATA_W-1:0] data_q;
  logic                  err_q;
  logic                  range_bad, last_word;
  logic                  req_valid, cfg_wen;

  // Range check one bit wider so first_sel+reg_count cannot wrap past NUM_REGS.
  assign range_bad = (reg_count == '0) ||
                     (({1'b0, first_sel} + {1'b0, reg_count}) > NUM_REGS_W);
  assign last_word = (SEL_W'(idx_q + 1'b1) == count_q);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = range_bad ? ST_DONE : ST_REQ;
      ST_REQ:   if (abort) state_d = ST_IDLE;
                else if (bus.mem_req_ready) state_d = ST_WAIT;
      ST_WAIT:  if (abort) state_d = ST_IDLE;
                else if (bus.mem_rsp_valid) state_d = ST_WRITE;
      ST_WRITE: if (abort) state_d = ST_IDLE;
                else state_d = last_word ? ST_DONE : ST_REQ;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: descriptor latch, word index, captured word. config_sel/data
  // only change on the edge into WRITE, so they hold between writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      base_q  <= '0;
      first_q <= '0;
      count_q <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) begin
          base_q  <= base_addr & ~ADDR_W'(3);
          first_q <= first_sel;
          count_q <= reg_count;
          err_q   <= range_bad;
          idx_q   <= '0;
        end
        ST_WAIT: if (bus.mem_rsp_valid && !abort) begin
          data_q <= bus.mem_rsp_data;
          sel_q  <= first_q + idx_q;
        end
        ST_WRITE: idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Output logic. A write already in WRITE goes out even with abort; done/err
  // are suppressed by abort so a cancelled load never reports completion.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    req_valid = (state_q == ST_REQ);
    cfg_wen   = (state_q == ST_WRITE);
    done      = (state_q == ST_DONE) && !abort;
    err       = done && err_q;
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = base_q + ADDR_W'({idx_q, 2'b00});
  assign bus.config_wen    = cfg_wen;
  assign bus.config_sel    = sel_q;
  assign bus.config_data   = data_q;
endmodule
